// File: rtl/mvm_pkg.sv
// Shared constants, types and the rescale/saturate helper for the MVM engine.
package mvm_pkg;

    localparam int NUM_BIT    = 8;
    localparam int NUM_VECTOR = 8;
    localparam int DIM        = 8;
    localparam int FRAC_BITS  = NUM_BIT - 1;
    localparam int ACC_W      = 2 * NUM_BIT + $clog2(NUM_VECTOR);
    localparam int IDX_W      = (NUM_VECTOR > 1) ? $clog2(NUM_VECTOR) : 1;

    typedef logic signed [NUM_BIT-1:0]   elem_t;
    typedef logic signed [2*NUM_BIT-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]     acc_t;
    typedef logic [IDX_W-1:0]            idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam acc_t ELEM_MAX = acc_t'((2 ** (NUM_BIT - 1)) - 1);
    localparam acc_t ELEM_MIN = -ELEM_MAX - acc_t'(1);

    // Drop FRAC_BITS with an arithmetic shift (floor), then clamp to the element range.
    function automatic elem_t sat_rescale(input acc_t value);
        acc_t shifted;
        elem_t result;
        shifted = value >>> FRAC_BITS;
        if (shifted > ELEM_MAX) begin
            result = elem_t'(ELEM_MAX[NUM_BIT-1:0]);
        end else if (shifted < ELEM_MIN) begin
            result = elem_t'(ELEM_MIN[NUM_BIT-1:0]);
        end else begin
            result = elem_t'(shifted[NUM_BIT-1:0]);
        end
        return result;
    endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One output lane: signed multiply-accumulate with clear, plus a saturated result register.
module mvm_mac_lane
    import mvm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      acc_i,
    input  logic                      last_i,
    input  logic signed [NUM_BIT-1:0] x_i,
    input  logic signed [NUM_BIT-1:0] w_i,
    output logic signed [NUM_BIT-1:0] y_o
);

    acc_t  acc_q;
    acc_t  sum_d;
    prod_t prod;
    elem_t y_q;

    // Full-precision product, sign-extended into the accumulator width.
    always_comb begin
        prod  = x_i * w_i;
        sum_d = acc_q + acc_t'(prod);
    end

    // Accumulate while running; the last term goes straight into the rescaled output.
    // Clear wins over accumulate so a back-to-back start resets the sum on the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            if (clr_i) begin
                acc_q <= '0;
            end else if (acc_i) begin
                acc_q <= sum_d;
            end
            if (acc_i && last_i) begin
                y_q <= sat_rescale(sum_d);
            end
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/top_mvm.sv
// Sequential matrix-vector engine: one input vector per clock, DIM parallel MAC lanes.
module top_mvm
    import mvm_pkg::*;
(
    input  logic                      i_clk_topMvm,
    input  logic                      i_rst_topMvm,
    input  logic                      i_start_topMvm,
    input  logic signed [NUM_BIT-1:0] i_x_vectors [NUM_VECTOR-1:0][DIM-1:0],
    input  logic signed [NUM_BIT-1:0] i_wts [NUM_VECTOR-1:0],
    output logic signed [NUM_BIT-1:0] o_y_vector [DIM-1:0],
    output logic                      o_isAcc
);

    localparam idx_t LAST_IDX = idx_t'(NUM_VECTOR - 1);

    state_t state_q;
    idx_t   idx_q;
    logic   is_acc_q;
    logic   last_cyc;
    logic   clr;
    logic   acc_en;
    elem_t  w_sel;

    // Decode the lane controls; a start on the final cycle chains straight into a new run.
    always_comb begin
        acc_en   = (state_q == ST_ACC);
        last_cyc = acc_en && (idx_q == LAST_IDX);
        clr      = i_start_topMvm && ((state_q == ST_IDLE) || last_cyc);
        w_sel    = i_wts[idx_q];
    end

    // Control FSM with index counter and registered busy flag.
    always_ff @(posedge i_clk_topMvm or negedge i_rst_topMvm) begin
        if (!i_rst_topMvm) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            is_acc_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start_topMvm) begin
                        state_q  <= ST_ACC;
                        idx_q    <= '0;
                        is_acc_q <= 1'b1;
                    end
                end
                ST_ACC: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (i_start_topMvm) begin
                            state_q  <= ST_ACC;
                            is_acc_q <= 1'b1;
                        end else begin
                            state_q  <= ST_IDLE;
                            is_acc_q <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_q + idx_t'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    idx_q    <= '0;
                    is_acc_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_isAcc = is_acc_q;

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
            mvm_mac_lane u_lane (
                .clk    (i_clk_topMvm),
                .rst_n  (i_rst_topMvm),
                .clr_i  (clr),
                .acc_i  (acc_en),
                .last_i (last_cyc),
                .x_i    (i_x_vectors[idx_q][gi]),
                .w_i    (w_sel),
                .y_o    (o_y_vector[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_top_mvm.sv
// Directed self-checking bench for top_mvm.
module tb_top_mvm;
    import mvm_pkg::*;

    logic clk;
    logic rst_n;
    logic start;
    logic signed [NUM_BIT-1:0] x_vec [NUM_VECTOR-1:0][DIM-1:0];
    logic signed [NUM_BIT-1:0] wts [NUM_VECTOR-1:0];
    logic signed [NUM_BIT-1:0] y_vec [DIM-1:0];
    logic is_acc;

    int checks = 0;
    int errors = 0;
    int cyc;

    top_mvm dut (
        .i_clk_topMvm   (clk),
        .i_rst_topMvm   (rst_n),
        .i_start_topMvm (start),
        .i_x_vectors    (x_vec),
        .i_wts          (wts),
        .o_y_vector     (y_vec),
        .o_isAcc        (is_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int exp);
        for (int d = 0; d < DIM; d++) begin
            chk($sformatf("%s[%0d]", tag, d), int'(y_vec[d]), exp);
        end
    endtask

    task automatic fill(input int xv, input int wv);
        for (int k = 0; k < NUM_VECTOR; k++) begin
            wts[k] = elem_t'(wv);
            for (int d = 0; d < DIM; d++) begin
                x_vec[k][d] = elem_t'(xv);
            end
        end
    endtask

    // Floor-then-clamp reference for one lane from the current input arrays.
    function automatic int golden(input int d);
        int sum;
        int s;
        sum = 0;
        for (int k = 0; k < NUM_VECTOR; k++) begin
            sum += int'(x_vec[k][d]) * int'(wts[k]);
        end
        s = sum >>> FRAC_BITS;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    // Pulse start for one edge, then count edges until the busy flag drops.
    // restart_at >= 0 re-asserts start for one edge at that point of the run.
    task automatic do_run(input int restart_at, output int n);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("isacc_rise", int'(is_acc), 1);
        n = 0;
        while (is_acc === 1'b1 && n < 20) begin
            if (n == restart_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        $display("run done: cycles=%0d y0=%0d", n, y_vec[0]);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill(0, 0);

        // Reset
        #23;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_isacc", int'(is_acc), 0);
        chk_all("reset_y", 0);

        // Nominal: 8 * 64*16 = 8192 -> 64
        fill(64, 16);
        do_run(-1, cyc);
        chk("nominal_cycles", cyc, 8);
        chk_all("nominal_y", 64);

        // Positive saturation: 8 * 4096 = 32768 -> 256 -> 127
        fill(-64, -64);
        do_run(-1, cyc);
        chk("satpos_cycles", cyc, 8);
        chk_all("satpos_y", 127);

        // Negative saturation: 8 * -16256 -> -1016 -> -128
        fill(-128, 127);
        do_run(-1, cyc);
        chk_all("satneg_y", -128);

        // Truncation: 8 >>> 7 = 0, -8 >>> 7 = -1
        fill(1, 1);
        do_run(-1, cyc);
        chk_all("trunc_pos_y", 0);
        fill(-1, 1);
        do_run(-1, cyc);
        chk_all("trunc_neg_y", -1);

        // Pattern against floor+clamp reference
        for (int k = 0; k < NUM_VECTOR; k++) begin
            wts[k] = elem_t'(-64 - k * k);
            for (int d = 0; d < DIM; d++) x_vec[k][d] = elem_t'(-64 - k * d);
        end
        do_run(-1, cyc);
        for (int d = 0; d < DIM; d++) chk($sformatf("pattern_y[%0d]", d), int'(y_vec[d]), golden(d));

        // Start re-asserted mid-run is ignored
        fill(64, 16);
        do_run(3, cyc);
        chk("midstart_cycles", cyc, 8);
        chk_all("midstart_y", 64);
        repeat (2) @(posedge clk);
        #1;
        chk("midstart_idle", int'(is_acc), 0);

        // Back-to-back: start sampled on the edge that completes run 1
        fill(64, 16);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fill(-1, 1);
        chk("b2b_first_y0", int'(y_vec[0]), 64);
        chk("b2b_still_busy", int'(is_acc), 1);
        cyc = 0;
        while (is_acc === 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("b2b_cycles", cyc, 8);
        chk_all("b2b_second_y", -1);

        // Reset asserted mid-run clears outputs immediately
        fill(64, 16);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_isacc", int'(is_acc), 0);
        chk_all("midrst_y", 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run(-1, cyc);
        chk("postrst_cycles", cyc, 8);
        chk_all("postrst_y", 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
